// File: rtl/char_rom_num_bcd.sv
// Multi-digit numeric text source: sequential binary-to-BCD conversion into a
// double-buffered display register, served as ASCII per 16x16 overlay cell.

module char_rom_num_bcd_add3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);
  assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;
endmodule

module char_rom_num_bcd #(
  parameter int DIGITS   = 4,
  parameter int BIN_W    = 14,
  parameter int BLANK_LZ = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  input  logic [7:0]       char_xy,
  output logic [6:0]       char_code
);

  localparam int         BCD_W  = 4 * DIGITS;
  localparam int         CNT_W  = (BIN_W < 2) ? 1 : $clog2(BIN_W);
  localparam logic [3:0] LAST_X = 4'(DIGITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t           r_state, w_next;
  logic [BIN_W-1:0] r_shift;
  logic [BCD_W-1:0] r_bcd, r_disp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wovf, r_ovf;
  logic [6:0]       r_code;

  logic [BCD_W-1:0] w_adj, w_bcd_nxt;
  logic             w_out_bit, w_last;

  // Per-digit add-3 correction ahead of each shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    char_rom_num_bcd_add3 u_add3 (
      .i_nib (r_bcd[4*g +: 4]),
      .o_nib (w_adj[4*g +: 4])
    );
  end

  assign w_bcd_nxt = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};
  assign w_out_bit = w_adj[BCD_W-1];
  assign w_last    = (r_cnt == CNT_W'(BIN_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE:   if (load) w_next = S_CONV;
      S_CONV: begin
        busy = 1'b1;
        if (w_last) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // The final shift lands directly in the display register so the display
  // changes on the same edge that enters COMMIT and raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_wovf  <= 1'b0;
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (load) begin
          r_shift <= value;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_wovf  <= 1'b0;
        end
        S_CONV: begin
          r_bcd   <= w_bcd_nxt;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt + CNT_W'(1);
          r_wovf  <= r_wovf | w_out_bit;
          if (w_last) begin
            r_disp <= w_bcd_nxt;
            r_ovf  <= r_wovf | w_out_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign overflow = r_ovf;

  logic [3:0] w_x, w_y, w_nib;
  logic       w_lz;
  logic [6:0] w_code;

  assign w_x = char_xy[3:0];
  assign w_y = char_xy[7:4];

  always_comb begin
    w_nib  = 4'd0;
    w_lz   = 1'b1;
    w_code = 7'h20;
    // w_lz: every digit from the MSD down to column x is zero
    for (int i = 0; i < DIGITS; i++) begin
      if (4'(i) <= w_x && r_disp[4*(DIGITS-1-i) +: 4] != 4'd0) w_lz = 1'b0;
      if (4'(i) == w_x) w_nib = r_disp[4*(DIGITS-1-i) +: 4];
    end
    if (w_y == 4'd0 && w_x <= LAST_X) begin
      if (r_ovf)                                    w_code = 7'h2D;
      else if (w_nib > 4'd9)                        w_code = 7'h30;
      else if (BLANK_LZ != 0 && w_x != LAST_X && w_lz) w_code = 7'h20;
      else                                          w_code = 7'h30 + {3'b000, w_nib};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_code <= 7'h20;
    else     r_code <= w_code;
  end

  assign char_code = r_code;

endmodule

// File: tb/tb_char_rom_num_bcd.sv
// Bench for char_rom_num_bcd: directed and random loads checked against a
// decimal-arithmetic model, with leading-zero blanking on and off.

module tb_char_rom_num_bcd;

  logic        clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [13:0] value = '0;
  logic [7:0]  char_xy = '0;
  logic        busy0, done0, ovf0, busy1, done1, ovf1;
  logic [6:0]  code0, code1;

  int nassert = 0, nfail = 0;
  int mv = 0;                       // value the display should hold
  int pow10[4] = '{1, 10, 100, 1000};

  always #5 clk = ~clk;

  char_rom_num_bcd #(.DIGITS(4), .BIN_W(14), .BLANK_LZ(1)) u0 (
    .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy0), .done(done0),
    .overflow(ovf0), .char_xy(char_xy), .char_code(code0));

  char_rom_num_bcd #(.DIGITS(4), .BIN_W(14), .BLANK_LZ(0)) u1 (
    .clk(clk), .rst(rst), .value(value), .load(load), .busy(busy1), .done(done1),
    .overflow(ovf1), .char_xy(char_xy), .char_code(code1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_cell(input int v, input bit blank, input int xy);
    int x, y, d;
    x = xy & 15;
    y = xy >> 4;
    if (y != 0 || x >= 4) return 'h20;
    if (v > 9999) return 'h2D;
    d = (v / pow10[3-x]) % 10;
    if (blank && x < 3 && v < pow10[3-x]) return 'h20;
    return 'h30 + d;
  endfunction

  task automatic check_cells(input string tag);
    for (int x = 0; x < 4; x++) begin
      char_xy = 8'(x);
      tick;
      chk({tag, "_lz"}, int'(code0), exp_cell(mv, 1'b1, x));
      chk({tag, "_nz"}, int'(code1), exp_cell(mv, 1'b0, x));
    end
    chk({tag, "_ovf"}, int'(ovf0), int'(mv > 9999));
    chk({tag, "_ovf1"}, int'(ovf1), int'(mv > 9999));
  endtask

  // Load v; optionally re-pulse load (value 1111) after step intr.
  task automatic do_load(input int v, input int intr);
    value = 14'(v);
    load  = 1'b1;
    tick;
    load  = 1'b0;
    value = 14'($urandom_range(0, 16383));
    for (int k = 0; k < 15; k++) begin
      chk("busy", int'(busy0), 1);
      chk("done", int'(done0), int'(k == 14));
      if (k == 14) mv = v;
      if (k == intr) begin
        value = 14'd1111;
        load  = 1'b1;
      end
      tick;
      load = 1'b0;
    end
    chk("busy_end", int'(busy0), 0);
    chk("done_end", int'(done0), 0);
    tick;
    chk("busy_rearm", int'(busy0), 0);
  endtask

  initial begin
    bit [7:0] seq[8] = '{8'h00, 8'h01, 8'h10, 8'h02, 8'h04, 8'h03, 8'hFF, 8'h00};
    int ndone;

    #12;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_ovf", int'(ovf0), 0);
    chk("rst_code", int'(code0), 'h20);
    rst = 1'b0;
    tick;
    check_cells("zero_init");

    do_load(1234, -1);
    check_cells("v1234");

    // address edges and back-to-back changes of char_xy
    char_xy = seq[0];
    tick;
    for (int i = 0; i < 7; i++) begin
      char_xy = seq[i+1];
      #1;
      chk("xy_lat0", int'(code0), exp_cell(mv, 1'b1, int'(seq[i])));
      chk("xy_lat1", int'(code1), exp_cell(mv, 1'b0, int'(seq[i])));
      tick;
    end

    do_load(7, -1);      check_cells("v7");
    do_load(0, -1);      check_cells("v0");
    do_load(12345, -1);  check_cells("v12345");
    do_load(42, -1);     check_cells("v42");
    do_load(5678, 3);    check_cells("v5678_ign");

    for (int r = 0; r < 16; r++) begin
      do_load(int'($urandom_range(0, 16383)), -1);
      check_cells("rand");
    end

    // reset mid-conversion after a committed overflow
    do_load(12345, -1);
    chk("pre_rst_ovf", int'(ovf0), 1);
    value = 14'd9999;
    load  = 1'b1;
    tick;
    load  = 1'b0;
    repeat (6) tick;
    chk("mid_busy", int'(busy0), 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy0), 0);
    chk("arst_done", int'(done0), 0);
    chk("arst_ovf", int'(ovf0), 0);
    chk("arst_code", int'(code0), 'h20);
    mv = 0;
    tick;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (done0 || done1 || busy0) ndone++;
    end
    chk("no_done_after_rst", ndone, 0);
    check_cells("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
